// File: rtl/snake_game_ctrl.sv
// Snake game sequencer: key direction filtering, move tick, head stepping,
// wall/body collision, IDLE/RUN/OVER game FSM and LFSR food placement.
module snake_game_ctrl #(
    parameter int unsigned TICK_DIV = 7425000,
    parameter int unsigned H_DISP   = 1280,
    parameter int unsigned V_DISP   = 720,
    parameter int unsigned SIDE_W   = 40,
    parameter int unsigned BLOCK_W  = 20,
    parameter int unsigned INI_X    = 640,
    parameter int unsigned INI_Y    = 360,
    parameter int unsigned FOOD_X   = 400,
    parameter int unsigned FOOD_Y   = 400,
    parameter int unsigned MAX_LEN  = 16
) (
    input  logic        pixel_clk,
    input  logic        sys_rst_n,
    input  logic [3:0]  key,
    input  logic        body_hit,
    output logic [10:0] next_x,
    output logic [10:0] next_y,
    output logic [10:0] head_x,
    output logic [10:0] head_y,
    output logic [10:0] food_x,
    output logic [10:0] food_y,
    output logic [4:0]  snake_len,
    output logic        step,
    output logic        grow,
    output logic        restart,
    output logic [1:0]  game_state
);

    localparam int unsigned CW   = 11;
    localparam int unsigned LW   = 5;
    localparam int unsigned TW   = $clog2(TICK_DIV);
    localparam int unsigned NCOL = (H_DISP - 2 * SIDE_W) / BLOCK_W;

    localparam logic [CW-1:0] X_MIN  = CW'(SIDE_W);
    localparam logic [CW-1:0] X_MAX  = CW'(H_DISP - SIDE_W - BLOCK_W);
    localparam logic [CW-1:0] Y_MAX  = CW'(V_DISP - SIDE_W - BLOCK_W);
    localparam logic [CW-1:0] STEP_W = CW'(BLOCK_W);
    localparam logic [CW-1:0] RST_HX = CW'(INI_X);
    localparam logic [CW-1:0] RST_HY = CW'(INI_Y);
    localparam logic [CW-1:0] RST_FX = CW'(FOOD_X);
    localparam logic [CW-1:0] RST_FY = CW'(FOOD_Y);
    localparam logic [LW-1:0] RST_LEN = LW'(3);
    localparam logic [LW-1:0] LEN_MAX = LW'(MAX_LEN);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    localparam logic [1:0] GS_IDLE = 2'd0;
    localparam logic [1:0] GS_RUN  = 2'd1;
    localparam logic [1:0] GS_OVER = 2'd2;

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_CHECK, S_FOOD, S_OVER} state_e;

    state_e          state_q, state_d;
    logic [1:0]      gs_q, gs_d;
    logic [3:0]      ks1_q, ks_q;
    logic [1:0]      dir_cur_q, dir_cur_d;
    logic [1:0]      dir_pend_q, dir_pend_d;
    logic [TW-1:0]   tick_q, tick_d;
    logic [15:0]     lfsr_q, lfsr_d;
    logic [CW-1:0]   head_x_q, head_x_d, head_y_q, head_y_d;
    logic [CW-1:0]   next_x_q, next_x_d, next_y_q, next_y_d;
    logic [CW-1:0]   food_x_q, food_x_d, food_y_q, food_y_d;
    logic [LW-1:0]   len_q, len_d;
    logic            step_q, step_d, grow_q, grow_d, restart_q, restart_d;
    logic            rel_q, rel_d;

    logic [1:0]      key_dir;
    logic            pressed, dir_ok, tick, wall;
    logic [5:0]      col;
    logic [4:0]      row;
    logic [CW-1:0]   cand_x, cand_y;
    logic            cand_ok;

    // Highest-priority pressed key wins; opposite of the committed direction is ignored.
    assign pressed = ~&ks_q;
    assign key_dir = !ks_q[0] ? DIR_UP :
                     !ks_q[1] ? DIR_DOWN :
                     !ks_q[2] ? DIR_LEFT : DIR_RIGHT;
    assign dir_ok  = pressed && (key_dir != (dir_cur_q ^ 2'd1));
    assign tick    = (tick_q == TICK_LAST);

    assign wall = (next_x_q < X_MIN) || (next_x_q > X_MAX) ||
                  (next_y_q < X_MIN) || (next_y_q > Y_MAX);

    // Food candidate: col*20 built as (col<<4)+(col<<2).
    assign col     = lfsr_q[5:0];
    assign row     = lfsr_q[12:8];
    assign cand_x  = X_MIN + (CW'(col) << 4) + (CW'(col) << 2);
    assign cand_y  = X_MIN + (CW'(row) << 4) + (CW'(row) << 2);
    assign cand_ok = (32'(col) < NCOL) && !((cand_x == head_x_q) && (cand_y == head_y_q));

    assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    always_comb begin
        state_d    = state_q;
        dir_cur_d  = dir_cur_q;
        dir_pend_d = dir_pend_q;
        tick_d     = tick_q;
        head_x_d   = head_x_q;
        head_y_d   = head_y_q;
        next_x_d   = next_x_q;
        next_y_d   = next_y_q;
        food_x_d   = food_x_q;
        food_y_d   = food_y_q;
        len_d      = len_q;
        rel_d      = rel_q;
        step_d     = 1'b0;
        grow_d     = 1'b0;
        restart_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (dir_ok) dir_pend_d = key_dir;
                if (pressed) begin
                    state_d = S_RUN;
                    tick_d  = '0;
                end
            end
            S_RUN: begin
                if (tick) begin
                    // Direction is frozen from the tick until CHECK commits the move.
                    tick_d  = '0;
                    state_d = S_CHECK;
                    case (dir_pend_q)
                        DIR_UP:   next_y_d = head_y_q - STEP_W;
                        DIR_DOWN: next_y_d = head_y_q + STEP_W;
                        DIR_LEFT: next_x_d = head_x_q - STEP_W;
                        default:  next_x_d = head_x_q + STEP_W;
                    endcase
                end else begin
                    tick_d = tick_q + TW'(1);
                    if (dir_ok) dir_pend_d = key_dir;
                end
            end
            S_CHECK: begin
                if (wall || body_hit) begin
                    state_d = S_OVER;
                    rel_d   = 1'b0;
                end else begin
                    step_d    = 1'b1;
                    head_x_d  = next_x_q;
                    head_y_d  = next_y_q;
                    dir_cur_d = dir_pend_q;
                    if ((next_x_q == food_x_q) && (next_y_q == food_y_q)) begin
                        if (len_q < LEN_MAX) begin
                            grow_d = 1'b1;
                            len_d  = len_q + LW'(1);
                        end
                        state_d = S_FOOD;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_FOOD: begin
                if (dir_ok) dir_pend_d = key_dir;
                if (cand_ok) begin
                    food_x_d = cand_x;
                    food_y_d = cand_y;
                    state_d  = S_RUN;
                end
            end
            S_OVER: begin
                // A restart press counts only after every key was seen released.
                if (!pressed) begin
                    rel_d = 1'b1;
                end else if (rel_q) begin
                    restart_d  = 1'b1;
                    state_d    = S_IDLE;
                    head_x_d   = RST_HX;
                    head_y_d   = RST_HY;
                    next_x_d   = RST_HX;
                    next_y_d   = RST_HY;
                    food_x_d   = RST_FX;
                    food_y_d   = RST_FY;
                    len_d      = RST_LEN;
                    dir_cur_d  = DIR_RIGHT;
                    dir_pend_d = DIR_RIGHT;
                    tick_d     = '0;
                    rel_d      = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        case (state_d)
            S_IDLE:  gs_d = GS_IDLE;
            S_OVER:  gs_d = GS_OVER;
            default: gs_d = GS_RUN;
        endcase
    end

    always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= S_IDLE;
            gs_q       <= GS_IDLE;
            ks1_q      <= 4'hF;
            ks_q       <= 4'hF;
            dir_cur_q  <= DIR_RIGHT;
            dir_pend_q <= DIR_RIGHT;
            tick_q     <= '0;
            lfsr_q     <= 16'hACE1;
            head_x_q   <= RST_HX;
            head_y_q   <= RST_HY;
            next_x_q   <= RST_HX;
            next_y_q   <= RST_HY;
            food_x_q   <= RST_FX;
            food_y_q   <= RST_FY;
            len_q      <= RST_LEN;
            step_q     <= 1'b0;
            grow_q     <= 1'b0;
            restart_q  <= 1'b0;
            rel_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            gs_q       <= gs_d;
            ks1_q      <= key;
            ks_q       <= ks1_q;
            dir_cur_q  <= dir_cur_d;
            dir_pend_q <= dir_pend_d;
            tick_q     <= tick_d;
            lfsr_q     <= lfsr_d;
            head_x_q   <= head_x_d;
            head_y_q   <= head_y_d;
            next_x_q   <= next_x_d;
            next_y_q   <= next_y_d;
            food_x_q   <= food_x_d;
            food_y_q   <= food_y_d;
            len_q      <= len_d;
            step_q     <= step_d;
            grow_q     <= grow_d;
            restart_q  <= restart_d;
            rel_q      <= rel_d;
        end
    end

    assign next_x     = next_x_q;
    assign next_y     = next_y_q;
    assign head_x     = head_x_q;
    assign head_y     = head_y_q;
    assign food_x     = food_x_q;
    assign food_y     = food_y_q;
    assign snake_len  = len_q;
    assign step       = step_q;
    assign grow       = grow_q;
    assign restart    = restart_q;
    assign game_state = gs_q;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Scoreboard bench for snake_game_ctrl: expected step/grow/restart events are
// queued by the stimulus and checked by an independent monitor.
module tb_snake_game_ctrl;

    logic        pixel_clk = 1'b0;
    logic        sys_rst_n;
    logic [3:0]  key;
    logic        body_hit;
    logic [10:0] next_x, next_y, head_x, head_y, food_x, food_y;
    logic [4:0]  snake_len;
    logic        step, grow, restart;
    logic [1:0]  game_state;

    snake_game_ctrl #(.TICK_DIV(8)) dut (
        .pixel_clk (pixel_clk),
        .sys_rst_n (sys_rst_n),
        .key       (key),
        .body_hit  (body_hit),
        .next_x    (next_x),
        .next_y    (next_y),
        .head_x    (head_x),
        .head_y    (head_y),
        .food_x    (food_x),
        .food_y    (food_y),
        .snake_len (snake_len),
        .step      (step),
        .grow      (grow),
        .restart   (restart),
        .game_state(game_state)
    );

    always #5 pixel_clk = ~pixel_clk;

    typedef struct packed {
        logic        step;
        logic        grow;
        logic        restart;
        logic [10:0] hx;
        logic [10:0] hy;
        logic [4:0]  len;
        logic [1:0]  st;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  last_step = -1;
    bit  chk_int = 1'b0;

    function automatic void check(string name, int act, int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endfunction

    function automatic void push_ev(bit s, bit g, bit r, int hx, int hy, int len, int st);
        ev_t e;
        e.step = s; e.grow = g; e.restart = r;
        e.hx = 11'(hx); e.hy = 11'(hy); e.len = 5'(len); e.st = 2'(st);
        exp_q.push_back(e);
    endfunction

    always @(posedge pixel_clk) cyc++;

    // Monitor: every command pulse must match the next queued expectation.
    always @(negedge pixel_clk) begin
        if (sys_rst_n && (step || grow || restart)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: step=%0d grow=%0d restart=%0d head=(%0d,%0d) expected none",
                         step, grow, restart, head_x, head_y);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                check("ev_step", int'(step), int'(e.step));
                check("ev_grow", int'(grow), int'(e.grow));
                check("ev_restart", int'(restart), int'(e.restart));
                check("ev_head_x", int'(head_x), int'(e.hx));
                check("ev_head_y", int'(head_y), int'(e.hy));
                check("ev_len", int'(snake_len), int'(e.len));
                check("ev_state", int'(game_state), int'(e.st));
            end
            if (step) begin
                if (chk_int && last_step >= 0) check("step_interval", cyc - last_step, 9);
                last_step = cyc;
            end
        end
    end

    task automatic check_reset_vals(string tag);
        check({tag, "_state"}, int'(game_state), 0);
        check({tag, "_head_x"}, int'(head_x), 640);
        check({tag, "_head_y"}, int'(head_y), 360);
        check({tag, "_next_x"}, int'(next_x), 640);
        check({tag, "_next_y"}, int'(next_y), 360);
        check({tag, "_food_x"}, int'(food_x), 400);
        check({tag, "_food_y"}, int'(food_y), 400);
        check({tag, "_len"}, int'(snake_len), 3);
        check({tag, "_pulses"}, int'({step, grow, restart}), 0);
    endtask

    task automatic wait_step(string name, int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge pixel_clk);
            if (step) return;
        end
        check({name, "_timeout"}, int'(step), 1);
    endtask

    task automatic wait_state(string name, int v, int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge pixel_clk);
            if (int'(game_state) == v) break;
        end
        check(name, int'(game_state), v);
    endtask

    // Down, down, then left x12 from the reset head lands on the reset food.
    task automatic run_to_food(string tag);
        push_ev(1, 0, 0, 640, 380, 3, 1);
        push_ev(1, 0, 0, 640, 400, 3, 1);
        for (int i = 1; i <= 12; i++)
            push_ev(1, (i == 12), 0, 640 - 20 * i, 400, (i == 12) ? 4 : 3, 1);
        @(negedge pixel_clk);
        key = 4'b1101;
        wait_step({tag, "_s1"}, 40);
        key = 4'hF;
        wait_step({tag, "_s2"}, 20);
        key = 4'b1011;
        for (int i = 0; i < 12; i++) wait_step({tag, "_sl"}, 20);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int fx, fy;
        sys_rst_n = 1'b0;
        key       = 4'hF;
        body_hit  = 1'b0;
        repeat (3) @(negedge pixel_clk);
        check_reset_vals("rst_hold");
        sys_rst_n = 1'b1;
        repeat (5) @(negedge pixel_clk);
        check_reset_vals("rst_idle");

        // Right-only run to the wall; a left press mid-run is filtered out.
        chk_int = 1'b1;
        for (int i = 1; i <= 29; i++) push_ev(1, 0, 0, 640 + 20 * i, 360, 3, 1);
        key = 4'b0111;
        repeat (3) @(negedge pixel_clk);
        key = 4'hF;
        for (int i = 0; i < 15; i++) wait_step("right_s", 40);
        key = 4'b1011;
        for (int i = 0; i < 14; i++) wait_step("right_s", 40);
        key = 4'hF;
        wait_state("wall_over", 2, 30);
        check("wall_head_x", int'(head_x), 1220);
        check("wall_queue_empty", exp_q.size(), 0);
        repeat (30) @(negedge pixel_clk);
        check("over_holds", int'(game_state), 2);
        check("over_head_x", int'(head_x), 1220);
        chk_int = 1'b0;

        // Keys already released: a short up press restarts.
        push_ev(0, 0, 1, 640, 360, 3, 0);
        key = 4'b1110;
        @(negedge pixel_clk);
        key = 4'hF;
        repeat (10) @(negedge pixel_clk);
        check("restart1_done", exp_q.size(), 0);
        check_reset_vals("restart1");

        // Eat the food, then force a body collision while a key is held.
        run_to_food("eat");
        body_hit = 1'b1;
        wait_state("body_over", 2, 60);
        body_hit = 1'b0;
        check("body_head_x", int'(head_x), 400);
        check("body_head_y", int'(head_y), 400);
        check("body_len", int'(snake_len), 4);
        fx = int'(food_x);
        fy = int'(food_y);
        check("food_align_x", (fx - 40) % 20, 0);
        check("food_align_y", (fy - 40) % 20, 0);
        check("food_range_x", int'(fx >= 40 && fx <= 1220), 1);
        check("food_range_y", int'(fy >= 40 && fy <= 660), 1);
        check("food_moved", int'(fx != 400 || fy != 400), 1);
        repeat (10) @(negedge pixel_clk);
        check("held_key_no_restart", int'(game_state), 2);
        key = 4'hF;
        repeat (5) @(negedge pixel_clk);
        push_ev(0, 0, 1, 640, 360, 3, 0);
        key = 4'b1110;
        @(negedge pixel_clk);
        key = 4'hF;
        repeat (10) @(negedge pixel_clk);
        check("restart2_done", exp_q.size(), 0);
        check_reset_vals("restart2");

        // Reset asserted while food placement is pending.
        run_to_food("food_rst");
        #2;
        sys_rst_n = 1'b0;
        key = 4'hF;
        #1;
        check_reset_vals("mid_food_rst");
        repeat (3) @(negedge pixel_clk);
        sys_rst_n = 1'b1;
        repeat (60) @(negedge pixel_clk);
        check_reset_vals("after_food_rst");
        check("final_queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
